// File: rtl/carregador_pkg.sv
// Shared definitions for the instruction-memory program loader.
package carregador_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CONTAGEM,
        DADOS,
        CHECKSUM,
        FIM,
        ERRO
    } estado_t;

    localparam int unsigned BYTES_POR_PALAVRA = 4;
    localparam int unsigned TIMEOUT_PADRAO    = 65535;

endpackage

// File: rtl/carregador_programa_montador.sv
// Packs accepted bytes big-endian into 32-bit words; the finished word is held until the next one completes.
module montador_palavra
    import carregador_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        limpar,
    input  logic        carregar,
    input  logic [7:0]  byte_in,
    output logic        completa,
    output logic        palavra_pronta,
    output logic [31:0] palavra
);

    localparam int unsigned CW = $clog2(BYTES_POR_PALAVRA);

    logic [CW-1:0] contador;
    logic [31:0]   deslocamento;

    assign completa = carregar && (contador == CW'(BYTES_POR_PALAVRA - 1));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            contador       <= '0;
            deslocamento   <= '0;
            palavra_pronta <= 1'b0;
            palavra        <= '0;
        end else if (limpar) begin
            contador       <= '0;
            deslocamento   <= '0;
            palavra_pronta <= 1'b0;
        end else begin
            palavra_pronta <= completa;
            if (carregar) begin
                contador     <= contador + 1'b1;
                deslocamento <= {deslocamento[23:0], byte_in};
            end
            // Output word is a separate register so it stays stable after the strobe.
            if (completa)
                palavra <= {deslocamento[23:0], byte_in};
        end
    end

endmodule

// File: rtl/carregador_programa.sv
// Program loader: receives a counted, XOR-checksummed byte frame and writes it into instruction memory.
module carregador_programa
    import carregador_pkg::*;
#(
    parameter int unsigned ADDR_W  = 8,
    parameter int unsigned TIMEOUT = TIMEOUT_PADRAO
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [7:0]        byte_in,
    input  logic              byte_valid,
    output logic              byte_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_data,
    output logic              cpu_hold,
    output logic              done,
    output logic              erro
);

    localparam int unsigned TW = $clog2(TIMEOUT + 1);

    estado_t           estado;
    estado_t           proximo;
    logic [ADDR_W-1:0] indice;
    logic [ADDR_W-1:0] ultimo_indice;
    logic [7:0]        soma;
    logic [7:0]        n_menos_1;
    logic [TW-1:0]     timer;
    logic              aceito;
    logic              entrar;
    logic              expirou;
    logic              completa;
    logic              ultima_palavra;

    assign aceito         = byte_valid && byte_ready;
    assign entrar         = start && (estado inside {IDLE, FIM, ERRO});
    assign expirou        = !aceito && (timer == TW'(TIMEOUT - 1));
    assign ultima_palavra = completa && (indice == ultimo_indice);
    assign n_menos_1      = byte_in - 8'd1;

    montador_palavra u_montador (
        .clock          (clock),
        .reset          (reset),
        .limpar         (entrar),
        .carregar       (aceito && (estado == DADOS)),
        .byte_in        (byte_in),
        .completa       (completa),
        .palavra_pronta (mem_we),
        .palavra        (mem_data)
    );

    always_comb begin
        proximo = estado;
        case (estado)
            IDLE, FIM, ERRO:
                if (start) proximo = CONTAGEM;
            CONTAGEM:
                if (aceito)       proximo = DADOS;
                else if (expirou) proximo = ERRO;
            DADOS:
                if (ultima_palavra) proximo = CHECKSUM;
                else if (expirou)   proximo = ERRO;
            CHECKSUM:
                if (aceito)       proximo = (byte_in == soma) ? FIM : ERRO;
                else if (expirou) proximo = ERRO;
            default:
                proximo = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado     <= IDLE;
            byte_ready <= 1'b0;
            cpu_hold   <= 1'b0;
            done       <= 1'b0;
            erro       <= 1'b0;
        end else begin
            estado     <= proximo;
            byte_ready <= proximo inside {CONTAGEM, DADOS, CHECKSUM};
            cpu_hold   <= proximo inside {CONTAGEM, DADOS, CHECKSUM, ERRO};
            done       <= (proximo == FIM);
            erro       <= (proximo == ERRO);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            indice        <= '0;
            ultimo_indice <= '0;
            soma          <= '0;
            timer         <= '0;
            mem_addr      <= '0;
        end else begin
            if (entrar) begin
                indice <= '0;
                soma   <= '0;
                timer  <= '0;
            end else begin
                if (mem_we)
                    indice <= indice + 1'b1;
                if (aceito && (estado != CHECKSUM))
                    soma <= soma ^ byte_in;
                // A count of zero selects the full memory, so the last index is all ones.
                if (aceito && (estado == CONTAGEM))
                    ultimo_indice <= (byte_in == 8'd0) ? '1 : ADDR_W'(n_menos_1);
                if (byte_ready && !aceito)
                    timer <= timer + 1'b1;
                else
                    timer <= '0;
            end
            if (completa)
                mem_addr <= indice;
        end
    end

endmodule

// File: tb/tb_carregador_programa.sv
// Scoreboard bench for carregador_programa: directed frames, expected writes/results queued ahead of the monitor.
module tb_carregador_programa;

    typedef struct {
        logic [7:0]  a;
        logic [31:0] d;
    } wr_t;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  byte_in = '0;
    logic        byte_valid = 1'b0;
    logic        byte_ready;
    logic        mem_we;
    logic [7:0]  mem_addr;
    logic [31:0] mem_data;
    logic        cpu_hold;
    logic        done;
    logic        erro;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;
    wr_t         exp_w[$];
    logic [2:0]  exp_r[$];
    logic [7:0]  dados[$];
    logic        done_q = 1'b0;
    logic        erro_q = 1'b0;

    carregador_programa #(.ADDR_W(8), .TIMEOUT(16)) dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .byte_in    (byte_in),
        .byte_valid (byte_valid),
        .byte_ready (byte_ready),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_data   (mem_data),
        .cpu_hold   (cpu_hold),
        .done       (done),
        .erro       (erro)
    );

    always #5 clock = ~clock;

    task automatic chk(input string nome, input logic [63:0] atual, input logic [63:0] esperado);
        n_cmp++;
        if (atual !== esperado) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nome, atual, esperado, $time);
        end
    endtask

    // Monitor: pops an expected write on every strobe and an expected status on every done/erro rise.
    always @(negedge clock) begin
        wr_t        e;
        logic [2:0] r;
        if (mem_we) begin
            if (exp_w.size() == 0) begin
                chk("unexpected_write", {24'd0, mem_addr, mem_data}, 64'd0);
            end else begin
                e = exp_w.pop_front();
                chk("write_addr", {56'd0, mem_addr}, {56'd0, e.a});
                chk("write_data", {32'd0, mem_data}, {32'd0, e.d});
            end
        end
        if ((done && !done_q) || (erro && !erro_q)) begin
            if (exp_r.size() == 0) begin
                chk("unexpected_status", {61'd0, done, erro, cpu_hold}, 64'd0);
            end else begin
                r = exp_r.pop_front();
                chk("status_done_erro_hold", {61'd0, done, erro, cpu_hold}, {61'd0, r});
            end
        end
        done_q <= done;
        erro_q <= erro;
    end

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic gap(input int unsigned gap_max);
        int unsigned g;
        if (gap_max > 0) begin
            byte_valid = 1'b0;
            g = $urandom_range(gap_max, 0);
            repeat (g) tick();
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        int unsigned espera;
        espera = 0;
        byte_in    = b;
        byte_valid = 1'b1;
        while (!byte_ready && espera < 20) begin
            tick();
            espera++;
        end
        if (!byte_ready) chk("byte_accept_timeout", 64'd0, 64'd1);
        tick();
        byte_valid = 1'b0;
    endtask

    task automatic pulse_start;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("start_ready", {63'd0, byte_ready}, 64'd1);
        chk("start_hold",  {63'd0, cpu_hold},   64'd1);
        chk("start_done",  {63'd0, done},       64'd0);
        chk("start_erro",  {63'd0, erro},       64'd0);
    endtask

    // Sends start, count byte and the first nb bytes of dados; the checksum is sent separately.
    task automatic send_frame(input logic [7:0] n, input int unsigned nb, input int unsigned gap_max);
        pulse_start();
        gap(gap_max);
        send_byte(n);
        for (int unsigned i = 0; i < nb; i++) begin
            gap(gap_max);
            send_byte(dados[i]);
            if (i % 4 == 3) chk("we_latency", {63'd0, mem_we}, 64'd1);
        end
    endtask

    task automatic basic_load(input logic [7:0] cks, input int unsigned gap_max, input logic [2:0] res);
        dados = {8'h20, 8'h01, 8'h00, 8'h05, 8'h8C, 8'h02, 8'h00, 8'h00};
        exp_w.push_back('{a: 8'd0, d: 32'h2001_0005});
        exp_w.push_back('{a: 8'd1, d: 32'h8C02_0000});
        send_frame(8'd2, 8, gap_max);
        exp_r.push_back(res);
        gap(gap_max);
        send_byte(cks);
        chk("result_latency_done", {63'd0, done},     {63'd0, res[2]});
        chk("result_latency_erro", {63'd0, erro},     {63'd0, res[1]});
        chk("result_latency_hold", {63'd0, cpu_hold}, {63'd0, res[0]});
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_ready"}, {63'd0, byte_ready}, 64'd0);
        chk({tag, "_we"},    {63'd0, mem_we},     64'd0);
        chk({tag, "_addr"},  {56'd0, mem_addr},   64'd0);
        chk({tag, "_data"},  {32'd0, mem_data},   64'd0);
        chk({tag, "_hold"},  {63'd0, cpu_hold},   64'd0);
        chk({tag, "_done"},  {63'd0, done},       64'd0);
        chk({tag, "_erro"},  {63'd0, erro},       64'd0);
    endtask

    initial begin
        int unsigned n;
        logic [7:0]  cks;

        #12;
        check_reset_outputs("reset");
        reset = 1'b0;
        tick();
        chk("idle_ready", {63'd0, byte_ready}, 64'd0);

        // Good checksum: 02^20^01^00^05^8C^02^00^00 = A8.
        basic_load(8'hA8, 0, 3'b100);
        // Bad checksum: both words still written, then erro with the core held.
        basic_load(8'h2F, 0, 3'b011);
        // Same frame with random host gaps shorter than the timeout.
        basic_load(8'hA8, 5, 3'b100);

        // Timeout: five data bytes of a two-word frame, then silence.
        dados = {8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        exp_w.push_back('{a: 8'd0, d: 32'h1122_3344});
        send_frame(8'd2, 5, 0);
        exp_r.push_back(3'b011);
        n = 0;
        while (!erro && n < 100) begin
            tick();
            n++;
        end
        chk("timeout_cycles", {32'd0, n}, 64'd16);
        chk("timeout_hold",   {63'd0, cpu_hold}, 64'd1);
        chk("timeout_ready",  {63'd0, byte_ready}, 64'd0);

        // Full size: N=0 means 256 words of incrementing bytes.
        dados.delete();
        for (int unsigned i = 0; i < 1024; i++) dados.push_back(8'(i));
        for (int unsigned k = 0; k < 256; k++)
            exp_w.push_back('{a: 8'(k), d: {8'(4*k), 8'(4*k+1), 8'(4*k+2), 8'(4*k+3)}});
        cks = 8'd0;
        for (int unsigned i = 0; i < 1024; i++) cks = cks ^ dados[i];
        send_frame(8'd0, 1024, 0);
        exp_r.push_back(3'b100);
        send_byte(cks);
        chk("full_done", {63'd0, done}, 64'd1);
        chk("full_last_addr", {56'd0, mem_addr}, 64'd255);

        // Reset after the second byte of word 1.
        dados = {8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hB1, 8'hB2};
        exp_w.push_back('{a: 8'd0, d: 32'hA1A2_A3A4});
        send_frame(8'd2, 6, 0);
        reset = 1'b1;
        #2;
        check_reset_outputs("midreset");
        tick();
        tick();
        reset = 1'b0;
        byte_in    = 8'h5A;
        byte_valid = 1'b1;
        repeat (8) tick();
        byte_valid = 1'b0;
        chk("postreset_ready", {63'd0, byte_ready}, 64'd0);
        chk("postreset_hold",  {63'd0, cpu_hold},   64'd0);
        basic_load(8'hA8, 0, 3'b100);

        repeat (5) tick();
        chk("pending_writes",  {32'd0, 32'(exp_w.size())}, 64'd0);
        chk("pending_results", {32'd0, 32'(exp_r.size())}, 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "simulation time limit");
    end

endmodule
